muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the HiLo register resource. It accepts MULT/MULTU/DIV/DIVU requests from the datapath and iterates a radix-2 shift-add multiply or restoring divide over 32 cycles. It presents a single-cycle HiLo write, and holds Busy so the PC/controller stalls while the operation runs. The ALU's combinational HiLo path stays in place for MFHI/MFLO/MTHI/MTLO. This block owns HiLo writes for multiply and divide.

---
 rtl/muldiv_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HiLo writes (radix-2 shift-add / restoring divide).
// Optional macro MULDIV_EARLY_TERM_EN: multiplies exit early once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_hilo_en,
  output logic [2*WIDTH-1:0]   o_hilo_write,
  output logic                 o_div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;

  state_t               r_state;
  state_t               w_state_next;
  op_t                  r_op;
  logic                 r_sa;
  logic                 r_sb;
  logic                 r_dbz;
  logic [CW-1:0]        r_cnt;
  // Multiply: {upper partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_hilo_en;
  logic                 r_div_by_zero;
  logic [2*WIDTH-1:0]   r_hilo_write;

  logic                 w_signed;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_is_div;
  logic                 w_last;
  logic                 w_mul_zero;
  logic                 w_early;
  logic                 w_iter_done;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [2*WIDTH:0]     w_div_shift;
  logic [WIDTH:0]       w_div_trial;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_signed = ~i_op[0];
  assign w_sa     = w_signed & i_a[WIDTH-1];
  assign w_sb     = w_signed & i_b[WIDTH-1];
  assign w_a_mag  = w_sa ? -i_a : i_a;
  assign w_b_mag  = w_sb ? -i_b : i_b;

  assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Applies the sign correction to the unsigned result of the final iteration.
  function automatic logic [2*WIDTH-1:0] f_result(input op_t op, input logic sa, input logic sb,
                                                  input logic dbz, input logic [2*WIDTH-1:0] acc);
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    if (op == OP_MULT || op == OP_MULTU) begin
      return (sa ^ sb) ? -acc : acc;
    end
    lo = acc[WIDTH-1:0];
    hi = acc[2*WIDTH-1:WIDTH];
    if (sa ^ sb) lo = -lo;
    if (sa)      hi = -hi;
    if (dbz)     lo = '1;
    return {hi, lo};
  endfunction

  // NOTE: every signal driven here gets a default before any branch, so no latch can be inferred.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
    w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};

    w_div_shift = {r_acc, 1'b0};
    w_div_trial = w_div_shift[2*WIDTH:WIDTH] - {1'b0, r_opnd};
    w_div_next  = w_div_shift[2*WIDTH-1:0];
    if (!w_div_trial[WIDTH]) begin
      w_div_next = {w_div_trial[WIDTH-1:0], w_div_shift[WIDTH-1:1], 1'b1};
    end
  end

`ifdef MULDIV_EARLY_TERM_EN
  localparam int SW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   w_mul_mask;
  logic [SW-1:0]      w_skip_amt;
  logic [2*WIDTH-1:0] w_mul_skip;

  // The low WIDTH-r_cnt bits of the accumulator are the multiplier bits not yet consumed.
  assign w_mul_mask = {WIDTH{1'b1}} >> r_cnt;
  assign w_mul_zero = ((r_acc[WIDTH-1:0] & w_mul_mask) == '0);
  assign w_skip_amt = SW'(WIDTH) - SW'(r_cnt);
  assign w_mul_skip = r_acc >> w_skip_amt;
`else
  assign w_mul_zero = 1'b0;
`endif

  assign w_early     = !w_is_div && w_mul_zero;
  assign w_iter_done = w_last || w_early;

  always_comb begin
    w_acc_next = w_mul_next;
    if (w_is_div) begin
      w_acc_next = w_div_next;
`ifdef MULDIV_EARLY_TERM_EN
    end else if (w_early) begin
      w_acc_next = w_mul_skip;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_ITER;
      S_ITER:  if (w_iter_done) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: all working registers are reset so an aborted operation leaves nothing behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op          <= OP_MULT;
      r_sa          <= 1'b0;
      r_sb          <= 1'b0;
      r_dbz         <= 1'b0;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_opnd        <= '0;
      r_hilo_en     <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_hilo_write  <= '0;
    end else begin
      r_hilo_en     <= 1'b0;
      r_div_by_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op  <= op_t'(i_op);
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_dbz <= i_op[1] && (i_b == '0);
            r_cnt <= '0;
            if (i_op[1]) begin
              r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
              r_opnd <= w_b_mag;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
              r_opnd <= w_a_mag;
            end
          end
        end
        S_ITER: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_iter_done) begin
            r_hilo_en     <= 1'b1;
            r_div_by_zero <= r_dbz;
            r_hilo_write  <= f_result(r_op, r_sa, r_sb, r_dbz, w_acc_next);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_hilo_en     = r_hilo_en;
  assign o_div_by_zero = r_div_by_zero;
  assign o_hilo_write  = r_hilo_write;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes reference results, a negedge monitor pops
// and compares on every HiLo write pulse.
module tb_muldiv_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [63:0] hilo;
    logic        dbz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [1:0]    i_op;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_b;
  logic          o_busy;
  logic          o_hilo_en;
  logic [63:0]   o_hilo_write;
  logic          o_div_by_zero;

  exp_t scb[$];
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   n_issued  = 0;
  int   n_pulses  = 0;
  int   cyc       = 0;
  int   last_acc  = 0;
  exp_t last_exp;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_busy        (o_busy),
    .o_hilo_en     (o_hilo_en),
    .o_hilo_write  (o_hilo_write),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic plus the two architected special cases.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint          sa;
    longint          sbv;
    longint unsigned ua;
    longint unsigned ub;
    int              qa;
    int              qb;
    e.dbz  = 1'b0;
    e.hilo = '0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = 64'(a);
    ub  = 64'(b);
    case (op)
      2'b00: e.hilo = 64'(sa * sbv);
      2'b01: e.hilo = ua * ub;
      default: begin
        if (b == 32'h0) begin
          e.hilo = {a, 32'hFFFF_FFFF};
          e.dbz  = 1'b1;
        end else if (op == 2'b11) begin
          e.hilo = {a % b, a / b};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hilo = {32'h0, 32'h8000_0000};
        end else begin
          qa = int'(a);
          qb = int'(b);
          e.hilo = {32'(qa % qb), 32'(qa / qb)};
        end
      end
    endcase
    return e;
  endfunction

  // Waits for IDLE (hammering Start with junk if asked), then presents the operation.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hammer);
    int guard = 0;
    @(negedge clk);
    while (o_busy && guard < 200) begin
      if (hammer) begin
        i_start = 1'b1;
        i_op    = 2'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
      end else begin
        i_start = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    check("issue_wait_idle", 64'(o_busy), 64'h0);
    i_start  = 1'b1;
    i_op     = op;
    i_a      = a;
    i_b      = b;
    last_exp = model(op, a, b);
    scb.push_back(last_exp);
    n_issued++;
    last_acc = cyc;
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    i_start = 1'b0;
    while (o_busy && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    check("drain_idle", 64'(o_busy), 64'h0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_div_by_zero && !o_hilo_en) check("dbz_without_en", 64'(o_hilo_en), 64'h1);
      if (o_hilo_en) begin
        n_pulses++;
        if (scb.size() == 0) begin
          check("unexpected_hilo_en", 64'(o_hilo_en), 64'h0);
        end else begin
          e = scb.pop_front();
          check("hilo_write", o_hilo_write, e.hilo);
          check("div_by_zero", 64'(o_div_by_zero), 64'(e.dbz));
        end
      end
    end
  end

  initial begin
    int busy_cycles;
    int en_at;
    int prev_acc;
    rst     = 1'b1;
    i_start = 1'b0;
    i_op    = 2'b00;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(o_busy), 64'h0);
    check("reset_hilo_en", 64'(o_hilo_en), 64'h0);
    check("reset_hilo_write", o_hilo_write, 64'h0);
    check("reset_dbz", 64'(o_div_by_zero), 64'h0);
    rst = 1'b0;

    // MULTU all-ones with latency measurement.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    i_start     = 1'b0;
    busy_cycles = 0;
    en_at       = 0;
    while (o_busy && busy_cycles < 200) begin
      busy_cycles++;
      if (o_hilo_en) en_at = busy_cycles;
      @(negedge clk);
    end
`ifndef MULDIV_EARLY_TERM_EN
    check("busy_cycles", 64'(busy_cycles), 64'(W + 1));
    check("hilo_en_cycle", 64'(en_at), 64'(W + 1));
`endif
    check("multu_ref", last_exp.hilo, 64'hFFFF_FFFE_0000_0001);

    // Directed cases from the test plan and the corner cases.
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    drain();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    drain();
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    drain();
    issue(2'b11, 32'h1234_5678, 32'h0, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    check("hilo_hold", o_hilo_write, 64'h1234_5678_FFFF_FFFF);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drain();
    issue(2'b10, 32'hFFFF_FF00, 32'h0, 1'b0);
    drain();
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();

    // Start held high throughout: junk during Busy must be ignored.
    prev_acc = 0;
    for (int k = 0; k < 6; k++) begin
      issue(2'($urandom), pick_operand(), pick_operand(), 1'b1);
`ifndef MULDIV_EARLY_TERM_EN
      if (k > 0) check("b2b_spacing", 64'(last_acc - prev_acc), 64'(W + 2));
`endif
      prev_acc = last_acc;
    end
    drain();

    // Randomized operations.
    for (int k = 0; k < 40; k++) begin
      issue(2'($urandom), pick_operand(), pick_operand(), 1'b0);
    end
    drain();

    // Asynchronous reset in the middle of an iteration.
    issue(2'b01, $urandom, $urandom, 1'b0);
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(o_busy), 64'h0);
    check("abort_hilo_en", 64'(o_hilo_en), 64'h0);
    check("abort_hilo_write", o_hilo_write, 64'h0);
    scb.delete();
    n_issued--;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_abort_idle", 64'(o_busy), 64'h0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    drain();

    check("scoreboard_empty", 64'(scb.size()), 64'h0);
    check("pulse_count", 64'(n_pulses), 64'(n_issued));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
